// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier among NUM_REQ requesters.
// Define MULT_ARB_ZERO_BYPASS_EN to answer zero-operand requests directly with product 0.
module mult_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned XLEN    = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*XLEN-1:0] req_mcand,
  input  logic [NUM_REQ*XLEN-1:0] req_mplier,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [XLEN-1:0]         resp_product,
  output logic                    mult_start,
  output logic [XLEN-1:0]         mult_mcand,
  output logic [XLEN-1:0]         mult_mplier,
  input  logic                    mult_done,
  input  logic [XLEN-1:0]         mult_product
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IDW-1:0]  last_grant;
  logic [IDW-1:0]  id;
  logic [IDW-1:0]  sel;
  logic [IDW-1:0]  cand_idx;
  logic            sel_found;
  int unsigned     cand;
  logic [XLEN-1:0] sel_mcand;
  logic [XLEN-1:0] sel_mplier;
  logic [XLEN-1:0] mcand_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] product_q;
  logic            zero_op;

  // Search starts just after the last completed grant and wraps around.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand     = (32'(last_grant) + k) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!sel_found && req_valid[cand_idx]) begin
        sel       = cand_idx;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    sel_mcand  = '0;
    sel_mplier = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == IDW'(i)) begin
        sel_mcand  = req_mcand[i*XLEN +: XLEN];
        sel_mplier = req_mplier[i*XLEN +: XLEN];
      end
    end
  end

`ifdef MULT_ARB_ZERO_BYPASS_EN
  assign zero_op = (sel_mcand == '0) || (sel_mplier == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Next state; mult_done is deliberately not looked at in ISSUE since it may be stale.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = zero_op ? RESP : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mult_done) state_nxt = RESP;
      RESP:    if (resp_ready[id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      id         <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      product_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (sel_found) begin
            id       <= sel;
            mcand_q  <= sel_mcand;
            mplier_q <= sel_mplier;
            if (zero_op) product_q <= '0;
          end
        end
        WAIT:    if (mult_done) product_q <= mult_product;
        RESP:    if (resp_ready[id]) last_grant <= id;
        default: ;
      endcase
    end
  end

  // req_ready is combinational, so it is masked by reset to keep it low while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset && (state == IDLE) && sel_found) req_ready[sel] = 1'b1;
  end

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[id] = 1'b1;
  end

  assign resp_product = product_q;
  assign mult_start   = (state == ISSUE);
  assign mult_mcand   = mcand_q;
  assign mult_mplier  = mplier_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a fixed-latency multiplier stub and a response scoreboard.
// Build with +define+MULT_ARB_ZERO_BYPASS_EN to check the zero-operand bypass timing.
module tb_mult_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 64;
  localparam int unsigned LAT  = 3;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  localparam int unsigned ZLAT    = 1;
  localparam int unsigned ZSTARTS = 0;
`else
  localparam int unsigned ZLAT    = LAT + 2;
  localparam int unsigned ZSTARTS = 2;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_mcand = '0;
  logic [NREQ*W-1:0] req_mplier = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] resp_valid;
  logic [NREQ-1:0] resp_ready = '1;
  logic [W-1:0]    resp_product;
  logic            mult_start;
  logic [W-1:0]    mult_mcand;
  logic [W-1:0]    mult_mplier;
  logic            mult_done = 1'b0;
  logic [W-1:0]    mult_product = '0;

  typedef struct {
    int unsigned idx;
    logic [W-1:0] prod;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned npass = 0, nfail = 0, ntotal = 0;
  int unsigned cyc = 0, acc_cyc = 0, acc_cnt = 0, starts = 0;
  logic        sticky = 1'b0;

  mult_arbiter #(.NUM_REQ(NREQ), .XLEN(W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_mcand(req_mcand), .req_mplier(req_mplier),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_product(resp_product), .mult_start(mult_start),
    .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
    .mult_done(mult_done), .mult_product(mult_product)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int unsigned i);
    oh = NREQ'(1) << i;
  endfunction

  task automatic push(input int unsigned idx, input logic [W-1:0] p, input int unsigned lat);
    exp_t e;
    e.idx = idx; e.prod = p; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic request(input int unsigned idx, input logic [W-1:0] a, input logic [W-1:0] b);
    req_mcand[idx*W +: W]  = a;
    req_mplier[idx*W +: W] = b;
    req_valid[idx]         = 1'b1;
  endtask

  // Returns just after the accepting edge so the caller may drop req_valid.
  task automatic wait_accept(input int unsigned idx);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      got = req_ready[idx] & req_valid[idx];
    end
    check("accept_wait", 64'(got), 64'd1);
    @(posedge clock); #1;
  endtask

  task automatic wait_drain;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  // Multiplier stub: done pulses LAT cycles after the start cycle; sticky keeps done high afterwards.
  initial begin
    int unsigned cnt;
    logic busy;
    logic [W-1:0] pa, pb;
    cnt = 0; busy = 1'b0; pa = '0; pb = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        busy = 1'b0;
        mult_done = 1'b0;
      end else if (busy) begin
        cnt--;
        if (cnt == 0) begin
          busy = 1'b0;
          mult_done = 1'b1;
          mult_product = pa * pb;
        end else begin
          mult_done = 1'b0;
        end
      end else begin
        if (mult_start) begin
          pa = mult_mcand; pb = mult_mplier; cnt = LAT; busy = 1'b1; starts++;
        end
        if (!sticky) begin
          mult_done = 1'b0;
          mult_product = 64'h5A5A_5A5A_5A5A_5A5A;
        end
      end
    end
  end

  // Monitor: grant order, timing, stability and scoreboard comparison of responses.
  initial begin
    logic [NREQ-1:0] prev_rv;
    logic [W-1:0] prev_prod;
    exp_t e;
    prev_rv = '0; prev_prod = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        prev_rv = '0;
      end else begin
        check("ready_idle", 64'((req_ready != 0) && (mult_start || resp_valid != 0)), 64'd0);
        check("ready_valid", 64'(req_ready & ~req_valid), 64'd0);
        if ((req_ready & req_valid) != 0) begin
          check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
          if (exp_q.size() == 0) check("grant_unexpected", 64'(req_ready), 64'd0);
          else check("grant_index", 64'(req_ready), 64'(oh(exp_q[0].idx)));
          acc_cyc = cyc;
          acc_cnt++;
        end
        if (resp_valid != 0 && prev_rv == 0 && exp_q.size() != 0)
          check("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
        if (resp_valid != 0 && prev_rv != 0) begin
          check("hold_valid", 64'(resp_valid), 64'(prev_rv));
          check("hold_product", resp_product, prev_prod);
        end
        if ((resp_valid & resp_ready) != 0) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", 64'(resp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("resp_index", 64'(resp_valid), 64'(oh(e.idx)));
            check("resp_product", resp_product, e.prod);
          end
          prev_rv = '0;
        end else begin
          prev_rv = resp_valid;
        end
        prev_prod = resp_product;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, ntotal);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s0, a0;
    logic got;

    // Reset: outputs low even with every requester asking.
    req_valid = '1;
    req_mcand = '1;
    req_mplier = '1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_product", resp_product, 64'd0);
    check("rst_mult_start", 64'(mult_start), 64'd0);
    check("rst_mult_mcand", mult_mcand, 64'd0);
    check("rst_mult_mplier", mult_mplier, 64'd0);
    req_valid = '0; req_mcand = '0; req_mplier = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Four requesters held valid: grant order 0,1,2,3,0.
    s0 = starts;
    for (int unsigned i = 0; i < NREQ; i++) request(i, 64'(i + 1), 64'd10);
    push(0, 64'd10, LAT + 2); push(1, 64'd20, LAT + 2); push(2, 64'd30, LAT + 2);
    push(3, 64'd40, LAT + 2); push(0, 64'd10, LAT + 2);
    wait_accept(0);
    wait_accept(1); req_valid[1] = 1'b0;
    wait_accept(2); req_valid[2] = 1'b0;
    wait_accept(3); req_valid[3] = 1'b0;
    wait_accept(0); req_valid[0] = 1'b0;
    wait_drain();
    check("rr_starts", 64'(starts - s0), 64'd5);

    // Single requester 0: 2*3.
    s0 = starts;
    request(0, 64'd2, 64'd3);
    push(0, 64'd6, LAT + 2);
    wait_accept(0); req_valid[0] = 1'b0;
    wait_drain();
    check("single_starts", 64'(starts - s0), 64'd1);

    // Backpressure on requester 1 while requester 2 waits; other resp_ready bits are ignored.
    s0 = starts;
    resp_ready = 4'b1101;
    request(1, '1, 64'd3);
    push(1, 64'hFFFF_FFFF_FFFF_FFFD, LAT + 2);
    push(2, 64'd63, LAT + 2);
    wait_accept(1); req_valid[1] = 1'b0;
    request(2, 64'd7, 64'd9);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clock);
      got = resp_valid[1];
    end
    check("bp_resp_seen", 64'(got), 64'd1);
    a0 = acc_cnt;
    repeat (5) @(posedge clock);
    #1;
    check("bp_valid_held", 64'(resp_valid), 64'b0010);
    check("bp_product_held", resp_product, 64'hFFFF_FFFF_FFFF_FFFD);
    check("bp_no_accept", 64'(acc_cnt - a0), 64'd0);
    resp_ready = '1;
    wait_accept(2); req_valid[2] = 1'b0;
    wait_drain();
    check("bp_starts", 64'(starts - s0), 64'd2);

    // Stale done held high into the next ISSUE cycle.
    s0 = starts;
    sticky = 1'b1;
    request(3, 64'd5, 64'd6);
    request(0, 64'd4, 64'd4);
    push(3, 64'd30, LAT + 2);
    push(0, 64'd16, LAT + 2);
    wait_accept(3); req_valid[3] = 1'b0;
    wait_accept(0); req_valid[0] = 1'b0;
    wait_drain();
    sticky = 1'b0;
    check("stale_starts", 64'(starts - s0), 64'd2);

    // Reset during WAIT abandons the request; afterwards requester 0 wins over 3.
    request(2, 64'd3, 64'd3);
    push(2, 64'd9, LAT + 2);
    wait_accept(2); req_valid[2] = 1'b0;
    @(posedge clock); #1;
    request(0, 64'd11, 64'd13);
    request(3, 64'd2, 64'd2);
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_req_ready", 64'(req_ready), 64'd0);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_resp_product", resp_product, 64'd0);
    check("mid_rst_mult_start", 64'(mult_start), 64'd0);
    check("mid_rst_mult_mcand", mult_mcand, 64'd0);
    check("mid_rst_mult_mplier", mult_mplier, 64'd0);
    repeat (3) @(posedge clock);
    #1;
    push(0, 64'd143, LAT + 2);
    push(3, 64'd4, LAT + 2);
    reset = 1'b1;
    wait_accept(0); req_valid[0] = 1'b0;
    wait_accept(3); req_valid[3] = 1'b0;
    wait_drain();

    // Zero operands: product 0 on either path, bypass timing when enabled.
    s0 = starts;
    request(1, 64'd0, 64'd5);
    request(2, 64'd9, 64'd0);
    push(1, 64'd0, ZLAT);
    push(2, 64'd0, ZLAT);
    wait_accept(1); req_valid[1] = 1'b0;
    wait_accept(2); req_valid[2] = 1'b0;
    wait_drain();
    check("zero_starts", 64'(starts - s0), 64'(ZSTARTS));

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
